bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_pkg.sv | 26 ++
 rtl/bcd_digit_adj.sv | 13 +
 rtl/bin2bcd_seq.sv | 106 ++++++++++
 tb/tb_bin2bcd_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// digits_fit() is the elaboration-time check that DIGITS can hold 2^WIDTH-1.
package bin2bcd_pkg;

  localparam int DEFAULT_WIDTH  = 9;
  localparam int DEFAULT_DIGITS = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  function automatic bit digits_fit(input int width, input int digits);
    longint p10;
    longint maxv;
    p10 = 1;
    for (int i = 0; i < digits; i++) p10 = p10 * 10;
    maxv = (longint'(1) << width) - 1;
    return p10 > maxv;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction: a BCD digit of 5..9 gets +3 before the shift
// so that doubling carries correctly into the next decade.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // 4-bit wrap is intentional; legal digits never exceed 9 so the sum fits.
  assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? digit_in + BCD_ADJ_ADD : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one bit per clock,
// with valid/ready handshakes on both input and output.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH < 2 || !digits_fit(WIDTH, DIGITS)) begin : g_bad_params
      $error("bin2bcd_seq: DIGITS=%0d cannot represent WIDTH=%0d", DIGITS, WIDTH);
    end
  endgenerate

  state_t                   state, state_nxt;
  logic [WIDTH-1:0]         bin_sr;
  logic [DIGITS-1:0][3:0]   bcd_acc;
  logic [DIGITS-1:0][3:0]   bcd_adj;
  logic [BW-1:0]            adj_flat;
  logic [BW-1:0]            acc_shifted;
  logic [CW-1:0]            cnt;
  logic                     accept;
  logic                     last_shift;

  // Per-digit correction, applied to the accumulator before every shift.
  genvar d;
  generate
    for (d = 0; d < DIGITS; d++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_in  (bcd_acc[d]),
        .digit_out (bcd_adj[d])
      );
    end
  endgenerate

  assign adj_flat    = bcd_adj;
  assign acc_shifted = {adj_flat[BW-2:0], bin_sr[WIDTH-1]};
  assign accept      = in_valid & in_ready;
  assign last_shift  = (state == CONVERT) && (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = CONVERT;
      CONVERT: if (last_shift) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Outputs; in_ready is gated by rst so nothing is offered during reset.
  always_comb begin
    in_ready  = (state == IDLE) & ~rst;
    out_valid = (state == DONE);
    busy      = (state == CONVERT) || (state == DONE);
  end

  // Datapath: shift register, accumulator, counter, result holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sr  <= '0;
      bcd_acc <= '0;
      cnt     <= '0;
      out_bcd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bin_sr  <= in_bin;
            bcd_acc <= '0;
            cnt     <= '0;
          end
        end
        CONVERT: begin
          bcd_acc <= acc_shifted;
          bin_sr  <= {bin_sr[WIDTH-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
          if (last_shift) out_bcd <= acc_shifted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: reset, latency, backpressure,
// back-to-back accepts, asynchronous abort and a full 0..511 sweep.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.WIDTH(9), .DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] exp_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Stimulus driver only: offers v, waits for the result, stalls out_ready
  // for `stall` cycles, then completes the output handshake.
  task automatic do_conv(input logic [8:0] v, input int stall, output logic [11:0] bcd,
                         output int lat, output bit ok, output bit stable);
    int n;
    ok = 1'b1; stable = 1'b1; lat = 0; n = 0;
    out_ready = 1'b0; in_bin = v; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!out_valid) ok = 1'b0;
    bcd = out_bcd;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (out_bcd !== bcd || out_valid !== 1'b1) stable = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_bin = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_bcd !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_bcd=%h, want 0 0 0 000",
               in_ready, out_valid, busy, out_bcd);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [11:0] r; int lat; bit ok, st;
    do_conv(9'd23, 0, r, lat, ok, st);
    checks++;
    if (!ok || lat != 9) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles (ok=%b), want 9", lat, ok);
    end
    checks++;
    if (r !== 12'h023) begin
      errors++;
      $display("FAIL basic_23: out_bcd=%h want 023", r);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_hs: in_ready=%b out_valid=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_values();
    logic [8:0]  vin [3] = '{9'd511, 9'd0, 9'd256};
    logic [11:0] vexp[3] = '{12'h511, 12'h000, 12'h256};
    logic [11:0] r; int lat; bit ok, st;
    for (int i = 0; i < 3; i++) begin
      do_conv(vin[i], 0, r, lat, ok, st);
      checks++;
      if (!ok || r !== vexp[i]) begin
        errors++;
        $display("FAIL value_%0d: out_bcd=%h ok=%b want %h", vin[i], r, ok, vexp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n; bit hold_ok;
    out_ready = 1'b0; in_bin = 9'd100; in_valid = 1'b1; n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    hold_ok = out_valid;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b1 || out_bcd !== 12'h100 || in_ready !== 1'b0) hold_ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL backpressure_hold: out_valid=%b out_bcd=%h in_ready=%b want 1 100 0",
               out_valid, out_bcd, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_bcd !== 12'h100) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b out_bcd=%h want 0 100", out_valid, out_bcd);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] outs[$];
    int nacc, a0, a1;
    bit acc;
    nacc = 0; a0 = -1; a1 = -1;
    out_ready = 1'b1; in_bin = 9'd255; in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      acc = in_valid && in_ready;
      if (out_valid && out_ready) outs.push_back(out_bcd);
      if (acc) begin
        if (nacc == 0) a0 = c; else a1 = c;
        nacc++;
      end
      @(negedge clk);
      if (acc && nacc == 1) in_bin = 9'd9;
      if (acc && nacc == 2) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    checks++;
    if (nacc != 2 || (a1 - a0) != 11) begin
      errors++;
      $display("FAIL b2b_spacing: accepts=%0d spacing=%0d want 2 and 11", nacc, a1 - a0);
    end
    checks++;
    if (outs.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: results=%0d want 2", outs.size());
    end else if (outs[0] !== 12'h255 || outs[1] !== 12'h009) begin
      errors++;
      $display("FAIL b2b_order: got %h,%h want 255,009", outs[0], outs[1]);
    end
  endtask

  task automatic test_async_reset();
    int n; bit quiet;
    logic [11:0] r; int lat; bit ok, st;
    out_ready = 1'b1; in_bin = 9'd300; in_valid = 1'b1; n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_bcd !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b busy=%b in_ready=%b out_bcd=%h want 0 0 0 000",
               out_valid, busy, in_ready, out_bcd);
    end
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL async_reset_no_result: out_valid seen after abort, want none");
    end
    do_conv(9'd7, 0, r, lat, ok, st);
    checks++;
    if (!ok || r !== 12'h007) begin
      errors++;
      $display("FAIL post_reset_7: out_bcd=%h ok=%b want 007", r, ok);
    end
  endtask

  task automatic test_sweep();
    logic [11:0] r; int lat; bit ok, st;
    for (int v = 0; v < 512; v++) begin
      do_conv(9'(v), int'($urandom_range(0, 3)), r, lat, ok, st);
      checks++;
      if (!ok || !st || lat != 9 || r !== exp_bcd(v)) begin
        errors++;
        $display("FAIL sweep_%0d: out_bcd=%h lat=%0d ok=%b stable=%b want %h lat 9",
                 v, r, lat, ok, st, exp_bcd(v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
